// File: rtl/regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_port_arbiter
//  Purpose  : Shares the register file's single write port between the
//             pipeline writeback stage (absolute priority) and a small FIFO of
//             multiply/divide results. Keeps a scoreboard of registers still
//             waiting for an MD result and stalls decode on hazards against
//             them, or when a queued MD write has been starved too long.
//  Ports    : CLK, RST            - clock, synchronous active-high reset
//             wbWrite/wbReg/wbData - writeback write request (never blocked)
//             mdValid/mdReady/mdReg/mdData - MD result handshake into queue
//             idRs/idRt/idUsesRs/idUsesRt/idRegWrite/idDest/idMdIssue
//                                  - decode-stage hazard inputs
//             stall                - hold decode/fetch this cycle
//             RegWrite/writeReg/writeData - register file write port
//             pending              - scoreboard, bit n = reg n awaits MD
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wbWrite,
    input  logic [4:0]  wbReg,
    input  logic [31:0] wbData,
    input  logic        mdValid,
    output logic        mdReady,
    input  logic [4:0]  mdReg,
    input  logic [31:0] mdData,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic        idUsesRs,
    input  logic        idUsesRt,
    input  logic        idRegWrite,
    input  logic [4:0]  idDest,
    input  logic        idMdIssue,
    output logic        stall,
    output logic        RegWrite,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData,
    output logic [31:0] pending
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_SW = $clog2(STARVE_LIMIT + 1);

    logic [4:0]      r_qReg  [DEPTH];
    logic [31:0]     r_qData [DEPTH];
    logic [c_AW-1:0] r_rdPtr;
    logic [c_AW-1:0] r_wrPtr;
    logic [c_AW:0]   r_count;
    logic [c_SW-1:0] r_starve;
    logic [31:0]     r_pending;

    logic        w_empty;
    logic        w_full;
    logic        w_wbGrant;
    logic        w_pop;
    logic        w_push;
    logic [4:0]  w_headReg;
    logic [31:0] w_headData;
    logic        w_hazard;
    logic        w_starving;
    logic [31:0] w_pendingNext;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == (c_AW+1)'(DEPTH));
    assign w_headReg  = r_qReg[r_rdPtr];
    assign w_headData = r_qData[r_rdPtr];

    // WB to a real register always owns the port. Any other cycle the head
    // leaves the queue; a head aimed at r0 just disappears without a write.
    // Nothing drains while in reset so queued results are discarded unwritten.
    assign w_wbGrant = wbWrite & (wbReg != 5'd0);
    assign w_pop     = ~w_empty & ~w_wbGrant & ~RST;
    assign mdReady   = ~w_full & ~RST;
    assign w_push    = mdValid & mdReady;

    always_comb begin
        RegWrite  = 1'b0;
        writeReg  = 5'd0;
        writeData = 32'd0;
        if (!RST) begin
            if (w_wbGrant) begin
                RegWrite  = 1'b1;
                writeReg  = wbReg;
                writeData = wbData;
            end else if (w_pop && (w_headReg != 5'd0)) begin
                RegWrite  = 1'b1;
                writeReg  = w_headReg;
                writeData = w_headData;
            end
        end
    end

    assign w_hazard   = (idUsesRs   & r_pending[idRs])
                      | (idUsesRt   & r_pending[idRt])
                      | (idRegWrite & r_pending[idDest]);
    assign w_starving = (r_starve == c_SW'(STARVE_LIMIT));
    assign stall      = w_hazard | w_starving;
    assign pending    = r_pending;

    // Clear first, then set, so a simultaneous set of the same bit wins.
    always_comb begin
        w_pendingNext = r_pending;
        if (w_pop && (w_headReg != 5'd0))
            w_pendingNext[w_headReg] = 1'b0;
        if (idMdIssue && !stall && (idDest != 5'd0))
            w_pendingNext[idDest] = 1'b1;
        w_pendingNext[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rdPtr   <= '0;
            r_wrPtr   <= '0;
            r_count   <= '0;
            r_starve  <= '0;
            r_pending <= '0;
        end else begin
            if (w_push)
                r_wrPtr <= r_wrPtr + 1'b1;
            if (w_pop)
                r_rdPtr <= r_rdPtr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_pop || w_empty)
                r_starve <= '0;
            else if (!w_starving)
                r_starve <= r_starve + 1'b1;
            r_pending <= w_pendingNext;
        end
    end

    // Queue storage needs no reset: only entries below r_count are ever read.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_qReg[r_wrPtr]  <= mdReg;
            r_qData[r_wrPtr] <= mdData;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_port_arbiter
//  Purpose  : Self-checking bench for regfile_port_arbiter: directed scenarios
//             plus randomized traffic compared against a queue-based model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_port_arbiter;

    localparam int c_DEPTH = 2;
    localparam int c_LIMIT = 8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        wbWrite;
    logic [4:0]  wbReg;
    logic [31:0] wbData;
    logic        mdValid;
    logic        mdReady;
    logic [4:0]  mdReg;
    logic [31:0] mdData;
    logic [4:0]  idRs, idRt, idDest;
    logic        idUsesRs, idUsesRt, idRegWrite, idMdIssue;
    logic        stall;
    logic        RegWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;
    logic [31:0] pending;

    int nTests = 0;
    int nFail  = 0;

    // Reference model: an actual FIFO of outstanding MD results, a pending
    // set and a count of denied cycles.
    logic [4:0]  mReg  [$];
    logic [31:0] mData [$];
    logic [31:0] mPend  = '0;
    int          mStarve = 0;

    always #5 CLK = ~CLK;

    regfile_port_arbiter #(.DEPTH(c_DEPTH), .STARVE_LIMIT(c_LIMIT)) dut (
        .CLK(CLK), .RST(RST),
        .wbWrite(wbWrite), .wbReg(wbReg), .wbData(wbData),
        .mdValid(mdValid), .mdReady(mdReady), .mdReg(mdReg), .mdData(mdData),
        .idRs(idRs), .idRt(idRt), .idUsesRs(idUsesRs), .idUsesRt(idUsesRt),
        .idRegWrite(idRegWrite), .idDest(idDest), .idMdIssue(idMdIssue),
        .stall(stall), .RegWrite(RegWrite), .writeReg(writeReg),
        .writeData(writeData), .pending(pending)
    );

    function automatic bit model_stall();
        bit hz;
        hz = (idUsesRs && mPend[idRs]) || (idUsesRt && mPend[idRt])
          || (idRegWrite && mPend[idDest]);
        return hz || (mStarve == c_LIMIT);
    endfunction

    task automatic model_step();
        bit wbg, pop, push, st;
        logic [4:0]  r;
        logic [31:0] d;
        wbg  = wbWrite && (wbReg != 0);
        pop  = (mReg.size() > 0) && !wbg && !RST;
        push = mdValid && (mReg.size() < c_DEPTH) && !RST;
        st   = model_stall();
        if (RST) begin
            mReg.delete(); mData.delete(); mPend = '0; mStarve = 0;
        end else begin
            if (pop || mReg.size() == 0) mStarve = 0;
            else if (mStarve < c_LIMIT)  mStarve++;
            if (pop) begin
                r = mReg.pop_front();
                d = mData.pop_front();
                if (r != 0) mPend[r] = 1'b0;
            end
            if (idMdIssue && !st && idDest != 0) mPend[idDest] = 1'b1;
            if (push) begin
                mReg.push_back(mdReg);
                mData.push_back(mdData);
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        wbWrite = 0; wbReg = 0; wbData = 0;
        mdValid = 0; mdReg = 0; mdData = 0;
        idRs = 0; idRt = 0; idDest = 0;
        idUsesRs = 0; idUsesRt = 0; idRegWrite = 0; idMdIssue = 0;
    endtask

    task automatic test_reset();
        RST = 1; idle_inputs();
        #1;
        nTests++; if (RegWrite !== 1'b0) begin nFail++; $display("FAIL rst_regwrite: got %b want 0", RegWrite); end
        nTests++; if (mdReady !== 1'b0) begin nFail++; $display("FAIL rst_mdready: got %b want 0", mdReady); end
        cycle(); cycle();
        RST = 0;
        #1;
        nTests++; if (mdReady !== 1'b1) begin nFail++; $display("FAIL rst_mdready_after: got %b want 1", mdReady); end
        nTests++; if (stall !== 1'b0) begin nFail++; $display("FAIL rst_stall: got %b want 0", stall); end
        nTests++; if (pending !== 32'd0) begin nFail++; $display("FAIL rst_pending: got %h want 0", pending); end
        nTests++; if (RegWrite !== 1'b0) begin nFail++; $display("FAIL rst_regwrite_after: got %b want 0", RegWrite); end
    endtask

    task automatic test_wb_mux();
        wbWrite = 1; wbReg = 5; wbData = 32'h1234;
        #1;
        nTests++; if (RegWrite !== 1'b1 || writeReg !== 5'd5 || writeData !== 32'h1234) begin
            nFail++; $display("FAIL wb_write: got %b/%0d/%h want 1/5/1234", RegWrite, writeReg, writeData); end
        cycle();
        wbReg = 0;
        #1;
        nTests++; if (RegWrite !== 1'b0) begin nFail++; $display("FAIL wb_r0: got %b want 0", RegWrite); end
        cycle();
        idle_inputs();
    endtask

    task automatic test_md_scoreboard();
        idMdIssue = 1; idDest = 8;
        #1;
        nTests++; if (stall !== 1'b0) begin nFail++; $display("FAIL md_issue_stall: got %b want 0", stall); end
        cycle();
        idMdIssue = 0; idDest = 0;
        #1;
        nTests++; if (pending[8] !== 1'b1) begin nFail++; $display("FAIL md_pending_set: got %b want 1", pending[8]); end
        idRs = 8; idUsesRs = 1;
        #1;
        nTests++; if (stall !== 1'b1) begin nFail++; $display("FAIL md_raw_stall: got %b want 1", stall); end
        mdValid = 1; mdReg = 8; mdData = 32'hCAFE;
        #1;
        nTests++; if (RegWrite !== 1'b0) begin nFail++; $display("FAIL md_no_bypass: got %b want 0", RegWrite); end
        cycle();
        mdValid = 0; mdReg = 0; mdData = 0;
        #1;
        nTests++; if (RegWrite !== 1'b1 || writeReg !== 5'd8 || writeData !== 32'hCAFE) begin
            nFail++; $display("FAIL md_commit: got %b/%0d/%h want 1/8/cafe", RegWrite, writeReg, writeData); end
        nTests++; if (stall !== 1'b1) begin nFail++; $display("FAIL md_commit_stall: got %b want 1", stall); end
        cycle();
        nTests++; if (pending[8] !== 1'b0 || stall !== 1'b0) begin
            nFail++; $display("FAIL md_clear: got pend=%b stall=%b want 0/0", pending[8], stall); end
        idle_inputs();
    endtask

    task automatic test_queue_full();
        for (int i = 0; i < 5; i++) begin
            wbWrite = 1; wbReg = 5'(10 + i); wbData = 32'(100 + i);
            mdValid = (i < 3); mdReg = 5'(1 + i); mdData = 32'hA1 + 32'(i);
            #1;
            nTests++; if (mdReady !== (i < 2)) begin
                nFail++; $display("FAIL full_mdready[%0d]: got %b want %b", i, mdReady, (i < 2)); end
            nTests++; if (RegWrite !== 1'b1 || writeReg !== 5'(10 + i)) begin
                nFail++; $display("FAIL full_wbowns[%0d]: got %b/%0d want 1/%0d", i, RegWrite, writeReg, 10 + i); end
            cycle();
        end
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            #1;
            nTests++; if (RegWrite !== 1'b1 || writeReg !== 5'(1 + i) || writeData !== 32'hA1 + 32'(i)) begin
                nFail++; $display("FAIL full_drain[%0d]: got %b/%0d/%h want 1/%0d/%h", i, RegWrite, writeReg, writeData, 1 + i, 32'hA1 + 32'(i)); end
            cycle();
        end
        nTests++; if (RegWrite !== 1'b0 || mdReady !== 1'b1) begin
            nFail++; $display("FAIL full_empty: got rw=%b rdy=%b want 0/1", RegWrite, mdReady); end
    endtask

    task automatic test_starvation();
        wbWrite = 1; wbReg = 20; wbData = 32'h55;
        mdValid = 1; mdReg = 4; mdData = 32'h44;
        cycle();
        mdValid = 0; mdReg = 0; mdData = 0;
        for (int i = 1; i <= c_LIMIT; i++) begin
            #1;
            nTests++; if (stall !== 1'b0) begin nFail++; $display("FAIL starve_early[%0d]: got %b want 0", i, stall); end
            cycle();
        end
        for (int i = 0; i < 2; i++) begin
            #1;
            nTests++; if (stall !== 1'b1) begin nFail++; $display("FAIL starve_forced[%0d]: got %b want 1", i, stall); end
            cycle();
        end
        wbWrite = 0; wbReg = 0;
        #1;
        nTests++; if (RegWrite !== 1'b1 || writeReg !== 5'd4 || writeData !== 32'h44 || stall !== 1'b1) begin
            nFail++; $display("FAIL starve_drain: got %b/%0d/%h stall=%b want 1/4/44 stall=1", RegWrite, writeReg, writeData, stall); end
        cycle();
        nTests++; if (stall !== 1'b0 || RegWrite !== 1'b0) begin
            nFail++; $display("FAIL starve_release: got stall=%b rw=%b want 0/0", stall, RegWrite); end
        idle_inputs();
    endtask

    task automatic test_wrap();
        wbWrite = 1; wbReg = 21; wbData = 32'h0;
        mdValid = 1; mdReg = 9; mdData = 32'hD0;
        cycle();
        wbWrite = 0; wbReg = 0;
        for (int i = 1; i <= 4; i++) begin
            mdReg = 5'(9 + i); mdData = 32'hD0 + 32'(i);
            #1;
            nTests++; if (RegWrite !== 1'b1 || writeReg !== 5'(8 + i) || writeData !== 32'hD0 + 32'(i - 1)) begin
                nFail++; $display("FAIL wrap_order[%0d]: got %b/%0d/%h want 1/%0d/%h", i, RegWrite, writeReg, writeData, 8 + i, 32'hD0 + 32'(i - 1)); end
            nTests++; if (mdReady !== 1'b1) begin nFail++; $display("FAIL wrap_count[%0d]: got rdy=%b want 1", i, mdReady); end
            cycle();
        end
        mdValid = 0; mdReg = 0; mdData = 0;
        #1;
        nTests++; if (RegWrite !== 1'b1 || writeReg !== 5'd13 || writeData !== 32'hD4) begin
            nFail++; $display("FAIL wrap_last: got %b/%0d/%h want 1/13/d4", RegWrite, writeReg, writeData); end
        cycle();
        nTests++; if (RegWrite !== 1'b0) begin nFail++; $display("FAIL wrap_empty: got %b want 0", RegWrite); end
    endtask

    task automatic test_reset_mid();
        wbWrite = 1; wbReg = 22; wbData = 32'h1;
        idMdIssue = 1; idDest = 3;
        mdValid = 1; mdReg = 3; mdData = 32'h33;
        cycle();
        idMdIssue = 0; idDest = 0;
        mdReg = 6; mdData = 32'h66;
        cycle();
        idle_inputs();
        RST = 1;
        #1;
        nTests++; if (RegWrite !== 1'b0) begin nFail++; $display("FAIL rstmid_nowrite: got %b want 0", RegWrite); end
        nTests++; if (pending[3] !== 1'b1) begin nFail++; $display("FAIL rstmid_pend_before: got %b want 1", pending[3]); end
        cycle();
        RST = 0;
        #1;
        nTests++; if (pending !== 32'd0 || mdReady !== 1'b1 || stall !== 1'b0 || RegWrite !== 1'b0) begin
            nFail++; $display("FAIL rstmid_after: got pend=%h rdy=%b stall=%b rw=%b want 0/1/0/0", pending, mdReady, stall, RegWrite); end
    endtask

    task automatic test_random();
        bit          eRw, eRdy, eSt;
        logic [4:0]  eReg;
        logic [31:0] eData;
        for (int n = 0; n < 400; n++) begin
            RST        = ($urandom_range(0, 99) < 2);
            wbWrite    = ($urandom_range(0, 99) < 55);
            wbReg      = 5'($urandom_range(0, 7));
            wbData     = $urandom;
            mdValid    = ($urandom_range(0, 99) < 35);
            mdReg      = 5'($urandom_range(0, 7));
            mdData     = $urandom;
            idRs       = 5'($urandom_range(0, 7));
            idRt       = 5'($urandom_range(0, 7));
            idDest     = 5'($urandom_range(0, 7));
            idUsesRs   = 1'($urandom);
            idUsesRt   = 1'($urandom);
            idRegWrite = 1'($urandom);
            idMdIssue  = ($urandom_range(0, 99) < 25);
            #1;
            eRdy  = !RST && (mReg.size() < c_DEPTH);
            eSt   = model_stall();
            eRw   = 0; eReg = 0; eData = 0;
            if (!RST && wbWrite && wbReg != 0) begin
                eRw = 1; eReg = wbReg; eData = wbData;
            end else if (!RST && mReg.size() > 0 && mReg[0] != 0) begin
                eRw = 1; eReg = mReg[0]; eData = mData[0];
            end
            nTests++; if (RegWrite !== eRw) begin nFail++; $display("FAIL rnd_regwrite[%0d]: got %b want %b", n, RegWrite, eRw); end
            if (eRw) begin
                nTests++; if (writeReg !== eReg || writeData !== eData) begin
                    nFail++; $display("FAIL rnd_port[%0d]: got %0d/%h want %0d/%h", n, writeReg, writeData, eReg, eData); end
            end
            nTests++; if (mdReady !== eRdy) begin nFail++; $display("FAIL rnd_mdready[%0d]: got %b want %b", n, mdReady, eRdy); end
            nTests++; if (stall !== eSt) begin nFail++; $display("FAIL rnd_stall[%0d]: got %b want %b", n, stall, eSt); end
            nTests++; if (pending !== mPend) begin nFail++; $display("FAIL rnd_pending[%0d]: got %h want %h", n, pending, mPend); end
            cycle();
        end
        RST = 0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_wb_mux();
        test_md_scoreboard();
        test_queue_full();
        test_starvation();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_port_arbiter.md
# regfile_port_arbiter

Shares the register file's single write port between the pipeline writeback stage and the multi-cycle multiply/divide unit (MD). It also keeps a 32-bit scoreboard of registers awaiting an MD result and raises a decode-stage stall on RAW/WAW hazards against them. It sits between WB, the MD unit and the register file write inputs (RegWrite, writeReg, writeData).

## Interface
- DEPTH, 2, MD write-queue entries; power of two, ≥2
- STARVE_LIMIT, 8, consecutive denied cycles of a queued MD write before stall is forced; ≥1
- CLK  in  1  clock; all state updates on posedge
- RST  in  1  synchronous, active-high reset
- wbWrite  in  1  pipeline WB write request; never back-pressured
- wbReg  in  5  WB destination
- wbData  in  32  WB data
- mdValid  in  1  MD result valid
- mdReady  out  1  queue can accept an MD result
- mdReg  in  5  MD destination
- mdData  in  32  MD result
- idRs, idRt  in  5 each  decode source registers
- idUsesRs, idUsesRt  in  1 each  source actually read
- idRegWrite  in  1  decode instruction writes a register
- idDest  in  5  decode destination
- idMdIssue  in  1  decode instruction issues to MD; its result returns via mdValid
- stall  out  1  hold decode/fetch this cycle
- RegWrite  out  1  register file write enable
- writeReg  out  5  register file write address
- writeData  out  32  register file write data
- pending  out  32  scoreboard, bit n = register n awaits MD result

## Operation
- Write port mux, combinational. WB has absolute priority: if wbWrite and wbReg≠0, drive wbReg/wbData with RegWrite=1. Otherwise, if the queue is non-empty and the head destination ≠0, drive the head with RegWrite=1 and pop it. Otherwise RegWrite=0.
- Writes to register 0 never assert RegWrite. A queue head with mdReg=0 pops silently in any cycle WB is not writing.
- MD queue: FIFO of {mdReg, mdData}. Push on mdValid & mdReady. mdReady = !full & !RST. No same-cycle bypass: a push into an empty queue cannot drain in that cycle.
- Pop on grant. Push and pop in the same cycle are allowed; count stays unchanged. Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.
- Scoreboard set: bit idDest is set on the edge where idMdIssue & !stall & idDest≠0.
- Scoreboard clear: bit is cleared on the edge where the queue head for that register is popped.
- Set and clear of the same bit in one cycle cannot occur, because issue stalls on a pending destination. If it occurs anyway, set wins.
- hazard = (idUsesRs & pending[idRs]) | (idUsesRt & pending[idRt]) | (idRegWrite & pending[idDest]). pending[0] is always 0.
- Starvation counter: increments each cycle the queue is non-empty and the head is denied, saturating at STARVE_LIMIT. It clears on a pop or when the queue is empty.
- starving = (count == STARVE_LIMIT).
- stall = hazard | starving. Combinational.
- A forced stall starves decode so WB bubbles reach the port and the head drains.
- Reset clears the queue (entries dropped), scoreboard and counter. Reset mid-operation discards queued MD results without writing them.

## Timing
- Values during and after reset until the first stimulus: RegWrite=0, mdReady=0 while RST is high and 1 after, stall=0, pending=0.
- WB-to-port path is zero latency, combinational.
- MD accepted at edge N → RegWrite for it no earlier than cycle N+1. If WB is idle in N+1, the write commits at the N+1/N+2 edge; the pending bit clears at that same edge and stall drops in cycle N+2.
- A full queue drops mdReady in the cycle after the filling push. It rises again in the cycle after the first pop.
- Starvation: after STARVE_LIMIT consecutive denied cycles, stall is high from the next cycle until the cycle after the head pops.
- A decode read of a register in the same cycle that its queued MD write commits still sees stall=1. Decode proceeds one cycle later and reads the committed value.

## Test plan
- Reset, then wbWrite=1, wbReg=5, wbData=0x1234 → same cycle RegWrite=1, writeReg=5, writeData=0x1234. Then wbReg=0 → RegWrite=0.
- idMdIssue, idDest=8 → pending[8]=1 next cycle. Decode with idRs=8, idUsesRs → stall=1. mdValid, mdReg=8, mdData=0xCAFE with WB idle → write of 8 a cycle later, then pending[8]=0 and stall=0.
- WB writes every cycle while MD pushes 3 results with DEPTH=2 → mdReady=0 after 2 pushes, no MD write reaches the port. When WB goes idle, entries drain in FIFO order, one per cycle.
- Queue non-empty, WB busy continuously, STARVE_LIMIT=8 → stall rises after 8 denied cycles. On the first WB-idle cycle the head writes, and stall falls the following cycle.
- Simultaneous push and pop with the queue at count 1 → count stays 1 and data order is preserved across pointer wrap.
- RST asserted with 2 queued entries and pending[3]=1 → no RegWrite for them. Next cycle pending=0, mdReady=1 and stall=0.
